// File: rtl/dm_cmd_scheduler.sv
// DataMover command scheduler: descriptor FIFO, one-outstanding
// command sequencer, status FIFO and level interrupt.
module dm_cmd_scheduler #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_DEPTH_LOG2 = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
  input  logic                          set_stb,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
  input  logic                          get_stb,
  output logic [71:0]                   M_AXIS_CMD_TDATA,
  output logic                          M_AXIS_CMD_TVALID,
  input  logic                          M_AXIS_CMD_TREADY,
  input  logic [7:0]                    S_AXIS_STS_TDATA,
  input  logic                          S_AXIS_STS_TVALID,
  output logic                          S_AXIS_STS_TREADY,
  output logic                          irq
);

  localparam int AW = C_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_STS
  } state_t;

  state_t state, state_nx;

  logic [2:0]  wsel, rsel;
  logic        wr_addr, wr_len, wr_ctrl, flush;
  logic [31:0] addr_q;
  logic [22:0] btt_q;
  logic        enable, irq_en;
  logic [3:0]  tag_q;
  logic        cmd_ovf, sts_ovf;

  logic [58:0]   cmd_mem [DEPTH];
  logic [AW-1:0] cmd_wp, cmd_rp;
  logic [CW-1:0] cmd_cnt;
  logic          cmd_full, cmd_empty;
  logic          cmd_push, cmd_pop;
  logic [58:0]   cmd_head;
  logic [71:0]   cmd_q;

  logic [7:0]    sts_mem [DEPTH];
  logic [AW-1:0] sts_wp, sts_rp;
  logic [CW-1:0] sts_cnt;
  logic          sts_full, sts_empty;
  logic          sts_rdy, sts_push, sts_pop;
  logic          sts_stall, busy;
  logic [31:0]   rdata;
  logic          unused;

  assign unused = ^{set_addr[C_S_AXI_ADDR_WIDTH-1:5],
                    set_addr[1:0],
                    get_addr[C_S_AXI_ADDR_WIDTH-1:5],
                    get_addr[1:0]};

  assign wsel = set_addr[4:2];
  assign rsel = get_addr[4:2];
  assign wr_addr = set_stb && wsel == 3'd0;
  assign wr_len  = set_stb && wsel == 3'd1;
  assign wr_ctrl = set_stb && wsel == 3'd2;
  assign flush   = wr_ctrl && set_data[2];

  assign cmd_full  = cmd_cnt == CW'(DEPTH);
  assign cmd_empty = cmd_cnt == '0;
  assign cmd_push  = wr_len && !cmd_full && !flush;
  assign cmd_pop   = state == IDLE && enable && !cmd_empty;
  assign cmd_head  = cmd_mem[cmd_rp];

  assign sts_full  = sts_cnt == CW'(DEPTH);
  assign sts_empty = sts_cnt == '0;
  assign sts_rdy   = state == WAIT_STS && !sts_full;
  assign sts_push  = S_AXIS_STS_TVALID && sts_rdy;
  assign sts_pop   = get_stb && rsel == 3'd3 && !sts_empty;
  assign sts_stall = state == WAIT_STS && S_AXIS_STS_TVALID
                     && sts_full;
  assign busy      = state != IDLE;

  assign M_AXIS_CMD_TDATA  = cmd_q;
  assign M_AXIS_CMD_TVALID = state == ISSUE;
  assign S_AXIS_STS_TREADY = sts_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      btt_q   <= '0;
      enable  <= 1'b0;
      irq_en  <= 1'b0;
      tag_q   <= '0;
      cmd_ovf <= 1'b0;
      sts_ovf <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_addr) addr_q <= set_data[31:0];
      if (wr_len) btt_q <= set_data[22:0];
      if (wr_ctrl) begin
        enable <= set_data[0];
        irq_en <= set_data[1];
      end
      if (cmd_push) tag_q <= tag_q + 4'd1;
      if (flush) begin
        cmd_ovf <= 1'b0;
        sts_ovf <= 1'b0;
      end else begin
        if (wr_len && cmd_full) cmd_ovf <= 1'b1;
        if (sts_stall) sts_ovf <= 1'b1;
      end
      irq <= irq_en && !sts_empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) cmd_mem[i] <= '0;
    end else if (flush) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
    end else begin
      if (cmd_push) begin
        cmd_mem[cmd_wp] <= {tag_q, addr_q, set_data[22:0]};
        cmd_wp <= cmd_wp + AW'(1);
      end
      if (cmd_pop) cmd_rp <= cmd_rp + AW'(1);
      cmd_cnt <= cmd_cnt + CW'(cmd_push) - CW'(cmd_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
    end else if (cmd_pop) begin
      cmd_q <= {4'h0, cmd_head[58:55], cmd_head[54:23],
                1'b0, 1'b1, 6'h00, 1'b1, cmd_head[22:0]};
    end
  end

  // A status landing in the flush cycle is kept, so the
  // in-flight completion is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_wp  <= '0;
      sts_rp  <= '0;
      sts_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) sts_mem[i] <= '0;
    end else if (flush) begin
      sts_rp <= '0;
      if (sts_push) begin
        sts_mem[0] <= S_AXIS_STS_TDATA;
        sts_wp     <= AW'(1);
        sts_cnt    <= CW'(1);
      end else begin
        sts_wp  <= '0;
        sts_cnt <= '0;
      end
    end else begin
      if (sts_push) begin
        sts_mem[sts_wp] <= S_AXIS_STS_TDATA;
        sts_wp <= sts_wp + AW'(1);
      end
      if (sts_pop) sts_rp <= sts_rp + AW'(1);
      sts_cnt <= sts_cnt + CW'(sts_push) - CW'(sts_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (cmd_pop) state_nx = ISSUE;
      ISSUE:    if (M_AXIS_CMD_TREADY) state_nx = WAIT_STS;
      WAIT_STS: if (sts_push) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      rsel == 3'd0: rdata = addr_q;
      rsel == 3'd1: rdata = {9'h000, btt_q};
      rsel == 3'd2: rdata = {30'h0, irq_en, enable};
      rsel == 3'd3: rdata = {!sts_empty, 23'h0,
                             sts_empty ? 8'h00 : sts_mem[sts_rp]};
      rsel == 3'd4: rdata = {cmd_ovf, sts_ovf, 5'h00, busy, 8'h00,
                             8'(sts_cnt), 8'(cmd_cnt)};
      default:      rdata = '0;
    endcase
  end

  assign get_data = C_S_AXI_DATA_WIDTH'(rdata);

endmodule

// File: tb/tb_dm_cmd_scheduler.sv
// Directed bench for dm_cmd_scheduler: issue, overflow, stall,
// flush and async reset scenarios with hand-computed values.
module tb_dm_cmd_scheduler;

  logic        clk;
  logic        rst_n;
  logic [31:0] set_addr, set_data, get_addr, get_data;
  logic        set_stb, get_stb;
  logic [71:0] M_AXIS_CMD_TDATA;
  logic        M_AXIS_CMD_TVALID, M_AXIS_CMD_TREADY;
  logic [7:0]  S_AXIS_STS_TDATA;
  logic        S_AXIS_STS_TVALID, S_AXIS_STS_TREADY;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  dm_cmd_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .set_addr          (set_addr),
    .set_data          (set_data),
    .set_stb           (set_stb),
    .get_addr          (get_addr),
    .get_data          (get_data),
    .get_stb           (get_stb),
    .M_AXIS_CMD_TDATA  (M_AXIS_CMD_TDATA),
    .M_AXIS_CMD_TVALID (M_AXIS_CMD_TVALID),
    .M_AXIS_CMD_TREADY (M_AXIS_CMD_TREADY),
    .S_AXIS_STS_TDATA  (S_AXIS_STS_TDATA),
    .S_AXIS_STS_TVALID (S_AXIS_STS_TVALID),
    .S_AXIS_STS_TREADY (S_AXIS_STS_TREADY),
    .irq               (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    set_addr = {27'h0, idx, 2'b00};
    set_data = d;
    set_stb  = 1'b1;
    @(negedge clk);
    set_stb  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, input logic pop,
                    output logic [31:0] d);
    get_addr = {27'h0, idx, 2'b00};
    get_stb  = pop;
    #1 d = get_data;
    @(negedge clk);
    get_stb  = 1'b0;
  endtask

  task automatic wait_tvalid();
    for (int i = 0; i < 20; i++) begin
      if (M_AXIS_CMD_TVALID) break;
      @(negedge clk);
    end
    chk("tvalid_wait", M_AXIS_CMD_TVALID, 1);
  endtask

  task automatic accept();
    M_AXIS_CMD_TREADY = 1'b1;
    @(negedge clk);
    M_AXIS_CMD_TREADY = 1'b0;
  endtask

  task automatic send_sts(input logic [7:0] s);
    logic hs;
    hs = 1'b0;
    S_AXIS_STS_TDATA  = s;
    S_AXIS_STS_TVALID = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = S_AXIS_STS_TREADY;
      @(negedge clk);
    end
    S_AXIS_STS_TVALID = 1'b0;
    chk("sts_hs", hs, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [71:0] exp;
    logic        seen;
    rst_n = 1'b0;
    set_addr = '0;
    set_data = '0;
    set_stb  = 1'b0;
    get_addr = '0;
    get_stb  = 1'b0;
    M_AXIS_CMD_TREADY = 1'b0;
    S_AXIS_STS_TDATA  = '0;
    S_AXIS_STS_TVALID = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", M_AXIS_CMD_TVALID, 0);
    chk("rst_stsrdy", S_AXIS_STS_TREADY, 0);
    chk("rst_tdata", M_AXIS_CMD_TDATA, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(3'd4, 1'b0, d);
    chk("rst_info", d, 0);

    // single command, status, irq
    wr(3'd0, 32'h1000_0000);
    wr(3'd2, 32'h3);
    wr(3'd1, 32'h40);
    chk("tvalid_n1", M_AXIS_CMD_TVALID, 0);
    @(negedge clk);
    exp = {4'h0, 4'h0, 32'h1000_0000, 32'h4080_0040};
    chk("tvalid_n2", M_AXIS_CMD_TVALID, 1);
    chk("tdata_first", M_AXIS_CMD_TDATA, exp);
    repeat (5) begin
      @(negedge clk);
      chk("tdata_hold", {M_AXIS_CMD_TVALID, M_AXIS_CMD_TDATA},
          {1'b1, exp});
    end
    accept();
    chk("tvalid_drop", M_AXIS_CMD_TVALID, 0);
    chk("stsrdy_wait", S_AXIS_STS_TREADY, 1);
    S_AXIS_STS_TDATA  = 8'h80;
    S_AXIS_STS_TVALID = 1'b1;
    @(negedge clk);
    S_AXIS_STS_TVALID = 1'b0;
    chk("irq_m1", irq, 0);
    rd(3'd3, 1'b0, d);
    chk("status_m1", d, 32'h8000_0080);
    chk("irq_m2", irq, 1);
    rd(3'd1, 1'b0, d);
    chk("len_rd", d, 32'h40);
    rd(3'd4, 1'b0, d);
    chk("info_one", d, 32'h0000_0100);
    rd(3'd3, 1'b1, d);
    chk("status_pop", d, 32'h8000_0080);
    chk("irq_p1", irq, 1);
    @(negedge clk);
    chk("irq_p2", irq, 0);
    rd(3'd3, 1'b1, d);
    chk("status_empty", d, 0);
    rd(3'd4, 1'b0, d);
    chk("info_empty", d, 0);
    chk("no_reissue", M_AXIS_CMD_TVALID, 0);

    // overflow of descriptor FIFO, in-order issue
    do_reset();
    wr(3'd2, 32'h0);
    for (int i = 0; i < 5; i++) begin
      wr(3'd0, 32'h2000_0000 + 32'(i) * 32'h100);
      wr(3'd1, 32'h100 + 32'(i));
    end
    rd(3'd4, 1'b0, d);
    chk("info_cmdovf", d, 32'h8000_0004);
    wr(3'd2, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_tvalid();
      exp = {4'h0, 4'(i), 32'h2000_0000 + 32'(i) * 32'h100,
             32'h4080_0100 + 32'(i)};
      chk("tdata_seq", M_AXIS_CMD_TDATA, exp);
      accept();
      chk("one_outst", M_AXIS_CMD_TVALID, 0);
      send_sts(8'h80 | 8'(i));
    end
    rd(3'd4, 1'b0, d);
    chk("info_stsfull", d, 32'h8000_0400);

    // status FIFO full: stall, then drain
    wr(3'd0, 32'h3000_0000);
    wr(3'd1, 32'h55);
    wait_tvalid();
    chk("tdata_tag4", M_AXIS_CMD_TDATA,
        {4'h0, 4'h4, 32'h3000_0000, 32'h4080_0055});
    accept();
    S_AXIS_STS_TDATA  = 8'h84;
    S_AXIS_STS_TVALID = 1'b1;
    #1 chk("stsrdy_full", S_AXIS_STS_TREADY, 0);
    @(negedge clk);
    chk("stsrdy_stall", S_AXIS_STS_TREADY, 0);
    rd(3'd4, 1'b0, d);
    chk("info_stsovf", d, 32'hC100_0400);
    rd(3'd3, 1'b1, d);
    chk("status_q0", d, 32'h8000_0080);
    chk("stsrdy_free", S_AXIS_STS_TREADY, 1);
    @(negedge clk);
    S_AXIS_STS_TVALID = 1'b0;
    rd(3'd4, 1'b0, d);
    chk("info_after", d, 32'hC000_0400);
    for (int i = 1; i < 5; i++) begin
      rd(3'd3, 1'b1, d);
      chk("status_drain", d, 32'h8000_0080 | 32'(i));
    end
    wr(3'd2, 32'h4);
    rd(3'd4, 1'b0, d);
    chk("flush_sticky", d, 0);

    // flush during WAIT_STS
    do_reset();
    wr(3'd2, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wr(3'd0, 32'h4000_0000 + 32'(i));
      wr(3'd1, 32'h10);
    end
    wr(3'd2, 32'h1);
    wait_tvalid();
    chk("tdata_fl", M_AXIS_CMD_TDATA,
        {4'h0, 4'h0, 32'h4000_0000, 32'h4080_0010});
    accept();
    rd(3'd4, 1'b0, d);
    chk("info_prefl", d, 32'h0100_0003);
    wr(3'd2, 32'h5);
    rd(3'd4, 1'b0, d);
    chk("info_fl", d, 32'h0100_0000);
    send_sts(8'h80);
    rd(3'd4, 1'b0, d);
    chk("info_flsts", d, 32'h0000_0100);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= M_AXIS_CMD_TVALID;
    end
    chk("fl_noissue", seen, 0);

    // async reset during ISSUE
    do_reset();
    wr(3'd0, 32'h5000_0000);
    wr(3'd2, 32'h3);
    wr(3'd1, 32'h20);
    wait_tvalid();
    #2 rst_n = 1'b0;
    #1 chk("arst_tvalid", M_AXIS_CMD_TVALID, 0);
    chk("arst_tdata", M_AXIS_CMD_TDATA, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(3'd4, 1'b0, d);
    chk("arst_info", d, 0);
    rd(3'd2, 1'b0, d);
    chk("arst_ctrl", d, 0);
    rd(3'd0, 1'b0, d);
    chk("arst_addr", d, 0);
    repeat (3) @(negedge clk);
    chk("arst_idle", M_AXIS_CMD_TVALID, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
